// File: rtl/serial_byte_tx.sv
// serial_byte_tx
//   Queues bytes in a small FIFO and shifts each one out LSB first as a
//   strobed serial stream. Every bit is framed as HIGH_CYCLES clocks with
//   write_out high, then LOW_CYCLES clocks with write_out low. The receiver
//   samples data_out while write_out is high. A byte starts only when the
//   receiver raises status_in. After each byte, the transmitter waits for
//   status_in to fall before it considers the next one.
//
// Parameters
//   HIGH_CYCLES  clocks write_out is held high per bit
//   LOW_CYCLES   clocks write_out is held low per bit
//   DEPTH        FIFO entries, power of two in 2..16
//
// Ports
//   clock_1MHz    in   single clock, rising edge
//   rst           in   asynchronous active-high reset
//   tx_data_in    in   [7:0] byte to queue
//   tx_valid_in   in   byte offered this cycle
//   tx_ready_out  out  FIFO not full (from registered count only)
//   status_in     in   receiver ready-for-byte flag
//   data_out      out  serial data bit, LSB first
//   write_out     out  bit strobe
//   busy_out      out  transmitter not idle
//   count_out     out  [$clog2(DEPTH):0] FIFO occupancy 0..DEPTH

module serial_byte_tx #(
  parameter int unsigned HIGH_CYCLES = 10,
  parameter int unsigned LOW_CYCLES  = 10,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clock_1MHz,
  input  logic                     rst,
  input  logic [7:0]               tx_data_in,
  input  logic                     tx_valid_in,
  output logic                     tx_ready_out,
  input  logic                     status_in,
  output logic                     data_out,
  output logic                     write_out,
  output logic                     busy_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam int unsigned CYC_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned TW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [TW-1:0] HIGH_LAST = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LAST  = TW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic [7:0]      shift_byte;
  logic [2:0]      bit_idx;
  logic [TW-1:0]   phase_cnt;

  logic            push;
  logic            pop;

  // Ready depends only on the registered count. A pop in the same cycle
  // therefore does not open a slot for a push while the FIFO is full.
  assign tx_ready_out = (count_out != FULL);

  always_comb begin
    push = tx_valid_in && tx_ready_out;
    pop  = (state_q == IDLE) && (count_out != '0) && status_in;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop) state_d = HIGH;
      end
      HIGH: begin
        if (phase_cnt == HIGH_LAST) state_d = LOW;
      end
      LOW: begin
        if (phase_cnt == LOW_LAST) state_d = (bit_idx == 3'd7) ? WAIT_DROP : HIGH;
      end
      WAIT_DROP: begin
        // status_in is ignored while a byte is in flight. Here it must be low
        // before the next byte is allowed to start.
        if (!status_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage is not reset. The pointers and count define which entries are valid.
  always_ff @(posedge clock_1MHz) begin
    if (push) mem[wr_ptr] <= tx_data_in;
  end

  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_out <= count_out + CW'(1);
        2'b01:   count_out <= count_out - CW'(1);
        default: count_out <= count_out;
      endcase
    end
  end

  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_out   <= 1'b0;
      write_out  <= 1'b0;
      data_out   <= 1'b0;
      shift_byte <= '0;
      bit_idx    <= '0;
      phase_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      busy_out  <= (state_d != IDLE);
      write_out <= (state_d == HIGH);

      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_byte <= mem[rd_ptr];
            data_out   <= mem[rd_ptr][0];
            bit_idx    <= '0;
            phase_cnt  <= '0;
          end else begin
            data_out   <= 1'b0;
          end
        end
        HIGH: begin
          if (state_d == LOW) phase_cnt <= '0;
          else                phase_cnt <= phase_cnt + TW'(1);
        end
        LOW: begin
          if (state_d == LOW) begin
            phase_cnt <= phase_cnt + TW'(1);
          end else begin
            phase_cnt <= '0;
            // data_out changes only on the edge that starts a high phase.
            if (state_d == HIGH) begin
              bit_idx  <= bit_idx + 3'd1;
              data_out <= shift_byte[bit_idx + 3'd1];
            end
          end
        end
        WAIT_DROP: begin
          if (state_d == IDLE) data_out <= 1'b0;
        end
        default: begin
          phase_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_tx.sv
`timescale 1ns/1ps
module tb_serial_byte_tx;

  localparam int unsigned HC    = 10;
  localparam int unsigned LC    = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PER   = HC + LC;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    din = '0;
  logic          valid = 1'b0;
  logic          status = 1'b0;
  logic          ready, dout, wr, busy;
  logic [CW-1:0] cnt;

  int total = 0;
  int bad   = 0;

  serial_byte_tx #(.HIGH_CYCLES(HC), .LOW_CYCLES(LC), .DEPTH(DEPTH)) dut (
    .clock_1MHz   (clk),
    .rst          (rst),
    .tx_data_in   (din),
    .tx_valid_in  (valid),
    .tx_ready_out (ready),
    .status_in    (status),
    .data_out     (dout),
    .write_out    (wr),
    .busy_out     (busy),
    .count_out    (cnt)
  );

  always #500 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue plus a transmission timeline. A byte that
  // starts at edge 0 has write_out high while (k mod PER) < HC and carries bit
  // k/PER for k in [0, 8*PER).
  typedef enum {M_IDLE, M_SEND, M_WAIT} mmode_t;
  mmode_t      mmode = M_IDLE;
  logic [7:0]  mq[$];
  logic [7:0]  mcur = '0;
  int unsigned mk = 0;
  int unsigned m_pre;
  logic        m_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mmode = M_IDLE;
      mk    = 0;
      mcur  = '0;
    end else begin
      m_pre  = mq.size();
      m_push = valid && (m_pre != DEPTH);
      case (mmode)
        M_IDLE: if (m_pre != 0 && status) begin
          mcur  = mq.pop_front();
          mk    = 0;
          mmode = M_SEND;
        end
        M_SEND: begin
          mk++;
          if (mk == 8 * PER) mmode = M_WAIT;
        end
        M_WAIT: if (!status) mmode = M_IDLE;
        default: mmode = M_IDLE;
      endcase
      if (m_push) mq.push_back(din);
    end
  end

  // Cycle-by-cycle comparison against the model
  logic e_wr, e_d;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      e_wr = (mmode == M_SEND) && ((mk % PER) < HC);
      e_d  = (mmode == M_SEND) ? mcur[3'(mk / PER)] : (mmode == M_WAIT) ? mcur[7] : 1'b0;
      chk("m_write", 8'(wr), 8'(e_wr));
      chk("m_data", 8'(dout), 8'(e_d));
      chk("m_busy", 8'(busy), 8'(mmode != M_IDLE));
      chk("m_count", 8'(cnt), 8'(mq.size()));
      chk("m_ready", 8'(ready), 8'(mq.size() != DEPTH));
    end
  end

  // Pulse monitor: records rise cycles, high widths and received bytes
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  logic        prev_wr = 1'b0;
  logic        bits[$];
  int unsigned rise_t[$];
  int unsigned hi_q[$];
  logic [7:0]  rx_bytes[$];
  logic [7:0]  asm_b;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (wr && !prev_wr) begin
        rise_cyc = cyc;
        rise_t.push_back(cyc);
        bits.push_back(dout);
        if (bits.size() == 8) begin
          for (int i = 0; i < 8; i++) asm_b[i] = bits[i];
          rx_bytes.push_back(asm_b);
          bits.delete();
        end
      end
      if (!wr && prev_wr) hi_q.push_back(cyc - rise_cyc);
      prev_wr = wr;
    end
  end

  task automatic clear_mon();
    bits.delete();
    rise_t.delete();
    hi_q.delete();
    rx_bytes.delete();
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    din   = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_rx(input int unsigned n, input int unsigned limit, input string name);
    int unsigned i = 0;
    while (rx_bytes.size() < n && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk(name, 8'(rx_bytes.size() >= n), 8'd1);
  endtask

  task automatic wait_rise(input int unsigned n, input int unsigned limit, input string name);
    int unsigned i = 0;
    while (rise_t.size() < n && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk(name, 8'(rise_t.size() >= n), 8'd1);
  endtask

  task automatic wait_idle(input int unsigned limit, input string name);
    int unsigned i = 0;
    while (busy && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk(name, 8'(busy), 8'd0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 2.5 us with random inputs
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #250;
      din    = 8'($urandom);
      valid  = 1'($urandom);
      status = 1'($urandom);
      chk("rst_write", 8'(wr), 8'd0);
      chk("rst_data", 8'(dout), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_count", 8'(cnt), 8'd0);
      chk("rst_ready", 8'(ready), 8'd1);
    end
    @(negedge clk);
    valid  = 1'b0;
    status = 1'b0;
    rst    = 1'b0;
    tick(2);

    // 0xAA: eight 10/10 pulses, data 0,1,0,1,...
    clear_mon();
    push(8'hAA);
    chk("aa_count", 8'(cnt), 8'd1);
    status = 1'b1;
    wait_rx(1, 400, "aa_timeout");
    tick(25);
    chk("aa_byte", rx_bytes[0], 8'hAA);
    chk("aa_pulses", 8'(hi_q.size()), 8'd8);
    for (int i = 0; i < 8; i++) chk("aa_high_w", 8'(hi_q[i]), 8'd10);
    for (int i = 1; i < 8; i++) chk("aa_period", 8'(rise_t[i] - rise_t[i-1]), 8'd20);
    chk("aa_waitdrop_busy", 8'(busy), 8'd1);
    chk("aa_waitdrop_wr", 8'(wr), 8'd0);
    status = 1'b0;
    tick(2);
    chk("aa_idle_busy", 8'(busy), 8'd0);
    chk("aa_idle_count", 8'(cnt), 8'd0);

    // 0x5C held back by status_in, then status drops mid-byte
    clear_mon();
    push(8'h5C);
    tick(1000);
    chk("5c_no_pulse", 8'(rise_t.size()), 8'd0);
    chk("5c_count", 8'(cnt), 8'd1);
    chk("5c_wr_before", 8'(wr), 8'd0);
    status = 1'b1;
    tick(1);
    chk("5c_start", 8'(wr), 8'd1);
    chk("5c_count0", 8'(cnt), 8'd0);
    tick(50);
    status = 1'b0;
    tick(109);
    chk("5c_busy_last", 8'(busy), 8'd1);
    tick(1);
    chk("5c_busy_wait", 8'(busy), 8'd1);
    chk("5c_wr_wait", 8'(wr), 8'd0);
    tick(1);
    chk("5c_busy_idle", 8'(busy), 8'd0);
    chk("5c_byte", rx_bytes[0], 8'h5C);

    // Five offers into a 4-deep FIFO
    clear_mon();
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("full_count", 8'(cnt), 8'd4);
    chk("full_ready", 8'(ready), 8'd0);
    for (int j = 0; j < 4; j++) begin
      status = 1'b1;
      tick(1);
      status = 1'b0;
      wait_idle(300, "fifo_timeout");
    end
    chk("fifo_nbytes", 8'(rx_bytes.size()), 8'd4);
    for (int j = 0; j < 4; j++) chk("fifo_order", rx_bytes[j], 8'(j + 1));
    chk("fifo_empty", 8'(cnt), 8'd0);

    // status_in held high sends only one byte
    clear_mon();
    push(8'h0F);
    push(8'hF0);
    status = 1'b1;
    wait_rx(1, 400, "hold_timeout1");
    tick(300);
    chk("hold_nbytes", 8'(rx_bytes.size()), 8'd1);
    chk("hold_count", 8'(cnt), 8'd1);
    chk("hold_first", rx_bytes[0], 8'h0F);
    status = 1'b0;
    tick(2);
    chk("hold_idle", 8'(busy), 8'd0);
    status = 1'b1;
    wait_rx(2, 400, "hold_timeout2");
    chk("hold_second", rx_bytes[1], 8'hF0);
    status = 1'b0;
    wait_idle(300, "hold_timeout3");

    // Reset during bit 3 high phase discards everything
    clear_mon();
    status = 1'b0;
    push(8'hA5);
    push(8'h33);
    status = 1'b1;
    wait_rise(4, 200, "rst_mid_timeout");
    tick(3);
    chk("rst_mid_pre_wr", 8'(wr), 8'd1);
    #100;
    rst = 1'b1;
    #1;
    chk("rst_mid_wr", 8'(wr), 8'd0);
    chk("rst_mid_count", 8'(cnt), 8'd0);
    chk("rst_mid_busy", 8'(busy), 8'd0);
    chk("rst_mid_data", 8'(dout), 8'd0);
    chk("rst_mid_ready", 8'(ready), 8'd1);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    tick(300);
    chk("rst_after_pulses", 8'(rise_t.size()), 8'd0);
    chk("rst_after_count", 8'(cnt), 8'd0);
    chk("rst_after_busy", 8'(busy), 8'd0);
    status = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_byte_tx.md
SERIAL_BYTE_TX -- requirements
Module: serial_byte_tx

Interface
REQ-001 SHALL have parameter HIGH_CYCLES, default 10, clocks write_out is held high per bit.
REQ-002 SHALL have parameter LOW_CYCLES, default 10, clocks write_out is held low per bit after the high phase.
REQ-003 SHALL have parameter DEPTH, default 4, byte FIFO entries (power of two, 2..16).
REQ-004 SHALL have port clock_1MHz  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port tx_data_in  in  8  byte to transmit.
REQ-007 SHALL have port tx_valid_in  in  1  byte offered this cycle.
REQ-008 SHALL have port tx_ready_out  out  1  FIFO can accept a byte (not full).
REQ-009 SHALL have port status_in  in  1  receiver ready-for-byte flag.
REQ-010 SHALL have port data_out  out  1  serial data bit, LSB first.
REQ-011 SHALL have port write_out  out  1  bit strobe; receiver samples data_out while high.
REQ-012 SHALL have port busy_out  out  1  high outside IDLE.
REQ-013 SHALL have port count_out  out  $clog2(DEPTH)+1  FIFO occupancy 0..DEPTH.

Function
REQ-014 SHALL push tx_data_in into the FIFO on a rising edge where tx_valid_in=1 and tx_ready_out=1; otherwise the offer is dropped.
REQ-015 SHALL drive tx_ready_out = (count_out != DEPTH), from registered count; a push while full is refused even if a pop occurs in the same cycle.
REQ-016 SHALL, on a simultaneous accepted push and pop, leave count_out unchanged and preserve FIFO order; pointers wrap modulo DEPTH.
REQ-017 SHALL implement states IDLE, HIGH, LOW, WAIT_DROP.
REQ-018 IDLE -> HIGH on an edge where count_out>0 and status_in=1: pop head byte into shift register, bit index=0, data_out=bit0, write_out=1 after that edge.
REQ-019 HIGH: write_out=1 for exactly HIGH_CYCLES clocks, then -> LOW with write_out=0; data_out unchanged.
REQ-020 LOW: write_out=0 for exactly LOW_CYCLES clocks; data_out held; then if bit index<7 -> HIGH with next bit on data_out, else -> WAIT_DROP.
REQ-021 SHALL change data_out only on the HIGH entry edge, never during a high phase.
REQ-022 Byte duration SHALL be 8*(HIGH_CYCLES+LOW_CYCLES) clocks (160 at defaults) from first write_out rise to WAIT_DROP entry.
REQ-023 WAIT_DROP -> IDLE on the first edge with status_in=0; no new byte starts until status_in has fallen, so a continuously high status_in SHALL NOT trigger a second byte.
REQ-024 A status_in drop during HIGH/LOW SHALL NOT abort the byte; the byte completes and WAIT_DROP exits on the next edge.
REQ-025 IDLE with count_out=0: write_out=0, data_out=0, busy_out=0 regardless of status_in.
REQ-026 All outputs except tx_ready_out SHALL be registered; tx_ready_out SHALL be a function of registered count only.

Reset
REQ-027 rst=1 SHALL immediately (without a clock) force state IDLE, data_out=0, write_out=0, busy_out=0, count_out=0, FIFO pointers 0, bit/cycle counters 0; tx_ready_out=1.
REQ-028 Reset mid-byte SHALL discard the in-flight byte and all queued bytes; none are retransmitted after release.
REQ-029 After rst falls, first accepted push is on the first rising edge meeting REQ-014.

Verification
REQ-030 Hold rst=1 2.5 us with random inputs -> write_out=0, data_out=0, busy_out=0, count_out=0, tx_ready_out=1 throughout.
REQ-031 Push 0xAA, status_in=1 -> 8 pulses each 10 high/10 low clocks, data_out per pulse 0,1,0,1,0,1,0,1, then WAIT_DROP; drop status_in -> IDLE, count_out=0.
REQ-032 status_in=0, push 0x5C -> no write_out pulse for 1000 clocks, count_out=1; raise status_in -> transmission of 0,0,1,1,1,0,1,0 starts one clock later.
REQ-033 status_in=0, offer 5 bytes 0x01..0x05 back-to-back -> first 4 accepted, count_out=4, tx_ready_out=0, 0x05 dropped; then toggle status_in per byte -> bytes emitted in order 0x01..0x04.
REQ-034 Queue 0x0F,0xF0, hold status_in=1 constant -> only 0x0F sent, count_out stays 1 until status_in falls and rises again, then 0xF0 sent.
REQ-035 Assert rst during bit 3 high phase -> write_out=0 within same cycle, count_out=0; after release with status_in=1 no pulse appears.
